// File: rtl/line_burst_adaptor.sv
// line_burst_adaptor: converts single 256-bit cache line requests into
// 4-beat x 64-bit memory bursts (fill and write-back).
// Optional beat-gap timeout abort is built when LINE_BURST_ADAPTOR_TIMEOUT_EN
// is defined; TIMEOUT_CYCLES sets the allowed idle cycles between beats.
module line_burst_adaptor #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  address_i,
  input  logic         read_i,
  input  logic         write_i,
  input  logic [255:0] line_i,
  output logic [255:0] line_o,
  output logic         resp_o,
  output logic         err_o,
  output logic [31:0]  address_o,
  output logic         read_o,
  output logic         write_o,
  output logic [63:0]  burst_o,
  input  logic [63:0]  burst_i,
  input  logic         resp_i
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

  state_e         state_q, state_d;
  logic [1:0]     k_q, k_d;
  logic [255:0]   line_q, line_d;
  logic [255:0]   buf_q, buf_d;
  logic [31:0]    addr_q, addr_d;
`ifdef LINE_BURST_ADAPTOR_TIMEOUT_EN
  logic [31:0]    cnt_q, cnt_d;
  logic           err_q, err_d;
`endif

  // Next-state: request acceptance, beat collection and completion.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    line_d  = line_q;
    buf_d   = buf_q;
    addr_d  = addr_q;
`ifdef LINE_BURST_ADAPTOR_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (read_i) begin
          addr_d  = {address_i[31:5], 5'b0};
          k_d     = '0;
          state_d = READ;
`ifdef LINE_BURST_ADAPTOR_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else if (write_i) begin
          addr_d  = {address_i[31:5], 5'b0};
          buf_d   = line_i;
          k_d     = '0;
          state_d = WRITE;
`ifdef LINE_BURST_ADAPTOR_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      READ, WRITE: begin
        if (resp_i) begin
          if (state_q == READ) begin
            line_d[{k_q, 6'b0} +: 64] = burst_i;
          end
          // k wraps 3->0 exactly on the DONE transition.
          k_d = k_q + 2'd1;
          if (k_q == 2'd3) begin
            state_d = DONE;
          end
`ifdef LINE_BURST_ADAPTOR_TIMEOUT_EN
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
          if (cnt_q == TIMEOUT_CYCLES - 32'd1) begin
            state_d = DONE;
            err_d   = 1'b1;
            k_d     = '0;
          end
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      line_q  <= '0;
      buf_q   <= '0;
      addr_q  <= '0;
`ifdef LINE_BURST_ADAPTOR_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      line_q  <= line_d;
      buf_q   <= buf_d;
      addr_q  <= addr_d;
`ifdef LINE_BURST_ADAPTOR_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign line_o    = line_q;
  assign address_o = addr_q;
  assign read_o    = (state_q == READ);
  assign write_o   = (state_q == WRITE);
  assign resp_o    = (state_q == DONE);
  assign burst_o   = buf_q[{k_q, 6'b0} +: 64];
`ifdef LINE_BURST_ADAPTOR_TIMEOUT_EN
  assign err_o     = err_q;
`else
  assign err_o     = 1'b0;
`endif

endmodule

// File: tb/tb_line_burst_adaptor.sv
// Self-checking bench for line_burst_adaptor: a transaction-level model
// (beat arrays, busy kind, beat count) is compared against the DUT on every
// falling edge, plus hand-computed literal expectations.
module tb_line_burst_adaptor;

`ifdef LINE_BURST_ADAPTOR_TIMEOUT_EN
  localparam int unsigned TO = 8;
`else
  localparam int unsigned TO = 255;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  address_i;
  logic         read_i, write_i;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic         resp_o, err_o;
  logic [31:0]  address_o;
  logic         read_o, write_o;
  logic [63:0]  burst_o, burst_i;
  logic         resp_i;

  line_burst_adaptor #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .address_i(address_i), .read_i(read_i),
    .write_i(write_i), .line_i(line_i), .line_o(line_o), .resp_o(resp_o),
    .err_o(err_o), .address_o(address_o), .read_o(read_o), .write_o(write_o),
    .burst_o(burst_o), .burst_i(burst_i), .resp_i(resp_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int resp_count = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Transaction model: busy kind (0 none, 1 fill, 2 write-back, 3 finishing),
  // beats taken so far, and the line as an array of four 64-bit words.
  int          m_kind;
  int          m_beats;
  int          m_idle;
  logic        m_err;
  logic [31:0] m_addr;
  logic [63:0] m_fill [4];
  logic [63:0] m_wb   [4];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_kind = 0; m_beats = 0; m_idle = 0; m_err = 1'b0; m_addr = '0;
      for (int i = 0; i < 4; i++) begin m_fill[i] = '0; m_wb[i] = '0; end
    end else begin
      if (m_kind == 0) begin
        if (read_i || write_i) begin
          m_kind  = read_i ? 1 : 2;
          m_addr  = address_i & 32'hFFFF_FFE0;
          m_beats = 0;
          m_idle  = 0;
          if (!read_i) for (int i = 0; i < 4; i++) m_wb[i] = line_i[64*i +: 64];
        end
      end else if (m_kind == 3) begin
        m_kind = 0;
        m_err  = 1'b0;
      end else if (resp_i) begin
        if (m_kind == 1) m_fill[m_beats] = burst_i;
        m_beats++;
        m_idle = 0;
        if (m_beats == 4) m_kind = 3;
      end else begin
        m_idle++;
`ifdef LINE_BURST_ADAPTOR_TIMEOUT_EN
        if (m_idle == int'(TO)) begin m_kind = 3; m_err = 1'b1; m_beats = 0; end
`endif
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("read_o", {255'b0, read_o}, {255'b0, m_kind == 1});
    chk("write_o", {255'b0, write_o}, {255'b0, m_kind == 2});
    chk("resp_o", {255'b0, resp_o}, {255'b0, m_kind == 3});
    chk("err_o", {255'b0, err_o}, {255'b0, m_err});
    chk("address_o", {224'b0, address_o}, {224'b0, m_addr});
    chk("line_o", line_o, {m_fill[3], m_fill[2], m_fill[1], m_fill[0]});
    if (m_kind == 2) chk("burst_o", {192'b0, burst_o}, {192'b0, m_wb[m_beats]});
    if (resp_o) resp_count++;
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Minimum-latency fill: request cycle 0, beats cycles 2-5, resp_o cycle 6.
  task automatic fill(input logic [31:0] a, input logic [63:0] b0, input logic [63:0] b1,
                      input logic [63:0] b2, input logic [63:0] b3,
                      input logic [255:0] exp_line, input logic [31:0] exp_addr);
    logic [63:0] bs [4];
    bs[0] = b0; bs[1] = b1; bs[2] = b2; bs[3] = b3;
    read_i = 1'b1; address_i = a;
    cyc();
    read_i = 1'b0;
    @(negedge clk);
    chk("lit_read_o_cycle1", {255'b0, read_o}, 256'd1);
    cyc();
    for (int i = 0; i < 4; i++) begin
      resp_i = 1'b1; burst_i = bs[i];
      cyc();
    end
    resp_i = 1'b0;
    @(negedge clk);
    chk("lit_resp_o_cycle6", {255'b0, resp_o}, 256'd1);
    chk("lit_line_o", line_o, exp_line);
    chk("lit_address_o", {224'b0, address_o}, {224'b0, exp_addr});
    cyc();
    @(negedge clk);
    chk("lit_resp_o_single", {255'b0, resp_o}, 256'd0);
    chk("lit_line_o_held", line_o, exp_line);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  logic [63:0] wb_seen [$];
  int          rc0;
  int          n;

  initial begin
    rst = 1'b1; address_i = '0; read_i = 1'b0; write_i = 1'b0;
    line_i = '0; burst_i = '0; resp_i = 1'b0;
    cyc(); cyc();
    chk("lit_reset_line_o", line_o, 256'd0);
    chk("lit_reset_addr", {224'b0, address_o}, 256'd0);
    chk("lit_reset_ctrl", {252'b0, read_o, write_o, resp_o, err_o}, 256'd0);
    rst = 1'b0;
    cyc();

    // Fill
    fill(32'h0000_1234, {16{4'h1}}, {16{4'h2}}, {16{4'h3}}, {16{4'h4}},
         {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}}, 32'h0000_1220);
    cyc();

    // Write-back with one-cycle gaps; read_i during the burst is ignored
    rc0 = resp_count;
    write_i = 1'b1; address_i = 32'h0000_5678;
    line_i = {{16{4'hA}}, {16{4'hB}}, {16{4'hC}}, {16{4'hD}}};
    cyc();
    write_i = 1'b0; read_i = 1'b1;
    cyc();
    read_i = 1'b0;
    for (int i = 0; i < 7; i++) begin
      resp_i = (i % 2 == 0);
      @(negedge clk);
      if (resp_i) wb_seen.push_back(burst_o);
      cyc();
    end
    // resp_i held high through DONE and IDLE must be ignored
    resp_i = 1'b1; burst_i = 64'hDEAD_BEEF_DEAD_BEEF;
    @(negedge clk);
    chk("lit_write_o_dropped", {255'b0, write_o}, 256'd0);
    cyc(); cyc();
    resp_i = 1'b0;
    cyc();
    chk("lit_wb_count", 256'(wb_seen.size()), 256'd4);
    if (wb_seen.size() == 4) begin
      chk("lit_wb_beat0", {192'b0, wb_seen[0]}, {192'b0, {16{4'hD}}});
      chk("lit_wb_beat1", {192'b0, wb_seen[1]}, {192'b0, {16{4'hC}}});
      chk("lit_wb_beat2", {192'b0, wb_seen[2]}, {192'b0, {16{4'hB}}});
      chk("lit_wb_beat3", {192'b0, wb_seen[3]}, {192'b0, {16{4'hA}}});
    end
    chk("lit_wb_resp_pulses", 256'(resp_count - rc0), 256'd1);
    chk("lit_line_after_wb", line_o, {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}});

    // Simultaneous read and write: read wins
    read_i = 1'b1; write_i = 1'b1; address_i = 32'hABCD_EF7F;
    cyc();
    read_i = 1'b0; write_i = 1'b0;
    @(negedge clk);
    chk("lit_simul_read_o", {255'b0, read_o}, 256'd1);
    chk("lit_simul_write_o", {255'b0, write_o}, 256'd0);
    chk("lit_simul_addr", {224'b0, address_o}, {224'b0, 32'hABCD_EF60});
    cyc();
    for (int i = 0; i < 4; i++) begin
      resp_i = 1'b1; burst_i = {16{4'(i + 5)}};
      cyc();
    end
    resp_i = 1'b0;
    cyc(); cyc();
    chk("lit_simul_line", line_o, {{16{4'h8}}, {16{4'h7}}, {16{4'h6}}, {16{4'h5}}});

    // Reset after two read beats
    rc0 = resp_count;
    read_i = 1'b1; address_i = 32'h0000_2000;
    cyc();
    read_i = 1'b0;
    cyc();
    resp_i = 1'b1; burst_i = {16{4'h9}};
    cyc();
    burst_i = {16{4'hE}};
    cyc();
    resp_i = 1'b0;
    rst = 1'b1;
    #1;
    chk("lit_rst_read_o", {255'b0, read_o}, 256'd0);
    chk("lit_rst_line_o", line_o, 256'd0);
    chk("lit_rst_resp_o", {255'b0, resp_o}, 256'd0);
    cyc();
    rst = 1'b0;
    cyc(); cyc();
    chk("lit_rst_no_resp", 256'(resp_count - rc0), 256'd0);
    fill(32'h0000_301F, 64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444,
         64'h5555_6666_7777_8888, 64'h9999_AAAA_BBBB_CCCC,
         {64'h9999_AAAA_BBBB_CCCC, 64'h5555_6666_7777_8888,
          64'h1111_2222_3333_4444, 64'h0123_4567_89AB_CDEF}, 32'h0000_3000);
    cyc();

`ifdef LINE_BURST_ADAPTOR_TIMEOUT_EN
    // Timeout: resp_o/err_o 8 cycles after read_o rises (cycle 9)
    read_i = 1'b1; address_i = 32'h0000_4000;
    cyc();
    read_i = 1'b0;
    n = 1;
    @(negedge clk);
    while (!resp_o && n < 50) begin
      cyc(); n++;
      @(negedge clk);
    end
    chk("lit_timeout_cycle", 256'(n), 256'd9);
    chk("lit_timeout_err", {255'b0, err_o}, 256'd1);
    cyc();
    @(negedge clk);
    chk("lit_timeout_idle", {254'b0, read_o, resp_o}, 256'd0);
`else
    // No timeout: read_o stays high for 100 idle cycles
    rc0 = resp_count;
    read_i = 1'b1; address_i = 32'h0000_4000;
    cyc();
    read_i = 1'b0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (read_o) n++;
      cyc();
    end
    chk("lit_wait_read_o", 256'(n), 256'd100);
    chk("lit_wait_no_resp", 256'(resp_count - rc0), 256'd0);
    for (int i = 0; i < 4; i++) begin
      resp_i = 1'b1; burst_i = {8{8'(8'hF0 + i)}};
      cyc();
    end
    resp_i = 1'b0;
    @(negedge clk);
    chk("lit_wait_resp", {255'b0, resp_o}, 256'd1);
    chk("lit_wait_line", line_o, {{8{8'hF3}}, {8{8'hF2}}, {8{8'hF1}}, {8{8'hF0}}});
`endif
    cyc(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
